// File: rtl/float_mul_param.sv
// float_mul_param: parametrised multi-cycle floating-point multiplier.
// Sequence: IDLE -> UNPACK -> MULT (one shift-add step per cycle) -> NORM -> ROUND -> DONE.
// Round-to-nearest-even. Denormal operands are treated as zero, and results too small
// to be normal are flushed to zero.
// Optional macro FLOAT_MUL_FLAGS_EN adds the exception flags output
// {invalid, overflow, underflow, inexact}.
module float_mul_param #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] float_in_1,
    input  logic [EXP_W+MAN_W:0] float_in_2,
    output logic [EXP_W+MAN_W:0] float_out,
`ifdef FLOAT_MUL_FLAGS_EN
    output logic [3:0]           flags,
`endif
    output logic                 ready
);

    localparam int unsigned W       = 1 + EXP_W + MAN_W;
    localparam int unsigned MW      = MAN_W + 1;
    localparam int unsigned PW      = 2 * MAN_W + 2;
    localparam int unsigned EW      = EXP_W + 2;
    localparam int unsigned CW      = $clog2(MAN_W + 1);
    localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sign;
    logic [EW-1:0]   r_exp;      // two's complement biased exponent
    logic [PW-1:0]   r_mcand;
    logic [MW-1:0]   r_mplier;
    logic [PW-1:0]   r_prod;
    logic [CW-1:0]   r_cnt;
    logic [MW-1:0]   r_man;
    logic            r_guard;
    logic            r_sticky;

    // Operand field decode and special-value classification
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sign;
    logic [EW-1:0]    w_exp_sum;

    assign w_ea      = r_a[W-2:MAN_W];
    assign w_eb      = r_b[W-2:MAN_W];
    assign w_fa      = r_a[MAN_W-1:0];
    assign w_fb      = r_b[MAN_W-1:0];
    assign w_sign    = r_a[W-1] ^ r_b[W-1];
    assign w_a_nan   = (w_ea == {EXP_W{1'b1}}) && (w_fa != '0);
    assign w_b_nan   = (w_eb == {EXP_W{1'b1}}) && (w_fb != '0);
    assign w_a_inf   = (w_ea == {EXP_W{1'b1}}) && (w_fa == '0);
    assign w_b_inf   = (w_eb == {EXP_W{1'b1}}) && (w_fb == '0);
    assign w_a_zero  = (w_ea == '0);
    assign w_b_zero  = (w_eb == '0);
    assign w_exp_sum = EW'(w_ea) + EW'(w_eb) - EW'(BIAS);

    // Normalisation: product lies in [1,4); pick the window under the leading one
    logic            w_msb;
    logic [MW-1:0]   w_norm_man;
    logic            w_norm_guard;
    logic            w_norm_sticky;

    assign w_msb         = r_prod[PW-1];
    assign w_norm_man    = w_msb ? r_prod[PW-1 -: MW] : r_prod[PW-2 -: MW];
    assign w_norm_guard  = w_msb ? r_prod[PW-1-MW]    : r_prod[PW-2-MW];
    assign w_norm_sticky = w_msb ? |r_prod[PW-2-MW:0] : |r_prod[PW-3-MW:0];

    // Round to nearest even, with renormalisation on mantissa carry-out
    logic            w_inc;
    logic [MW:0]     w_sum;
    logic            w_carry;
    logic [MAN_W-1:0] w_frac;
    logic [EW-1:0]   w_exp_rnd;
    logic            w_ovf;
    logic            w_unf;

    assign w_inc     = r_guard & (r_sticky | r_man[0]);
    assign w_sum     = {1'b0, r_man} + (MW+1)'(w_inc);
    assign w_carry   = w_sum[MW];
    assign w_frac    = w_carry ? w_sum[MW-1:1] : w_sum[MAN_W-1:0];
    assign w_exp_rnd = r_exp + EW'(w_carry);
    assign w_ovf     = ~w_exp_rnd[EW-1] & (w_exp_rnd[EW-2:0] >= (EW-1)'(EXP_MAX));
    assign w_unf     = w_exp_rnd[EW-1] | (w_exp_rnd == '0);

    // Control FSM and datapath registers; outputs change only on entry to DONE / exit from it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_man     <= '0;
            r_guard   <= 1'b0;
            r_sticky  <= 1'b0;
            float_out <= '0;
            ready     <= 1'b0;
`ifdef FLOAT_MUL_FLAGS_EN
            flags     <= 4'b0000;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        r_a     <= float_in_1;
                        r_b     <= float_in_2;
`ifdef FLOAT_MUL_FLAGS_EN
                        flags   <= 4'b0000;
`endif
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_sign <= w_sign;
                    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
                        float_out <= QNAN;
`ifdef FLOAT_MUL_FLAGS_EN
                        flags     <= 4'b1000;
`endif
                        ready     <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_a_inf || w_b_inf) begin
                        float_out <= {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FLOAT_MUL_FLAGS_EN
                        flags     <= 4'b0000;
`endif
                        ready     <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_a_zero || w_b_zero) begin
                        float_out <= {w_sign, {(W-1){1'b0}}};
`ifdef FLOAT_MUL_FLAGS_EN
                        flags     <= 4'b0000;
`endif
                        ready     <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_exp    <= w_exp_sum;
                        r_mcand  <= PW'({1'b1, w_fa});
                        r_mplier <= {1'b1, w_fb};
                        r_prod   <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_MULT;
                    end
                end
                S_MULT: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == CW'(MAN_W)) begin
                        r_cnt   <= '0;
                        r_state <= S_NORM;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                S_NORM: begin
                    r_man    <= w_norm_man;
                    r_guard  <= w_norm_guard;
                    r_sticky <= w_norm_sticky;
                    if (w_msb) begin
                        r_exp <= r_exp + EW'(1);
                    end
                    r_state  <= S_ROUND;
                end
                S_ROUND: begin
                    if (w_ovf) begin
                        float_out <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FLOAT_MUL_FLAGS_EN
                        flags     <= 4'b0101;
`endif
                    end else if (w_unf) begin
                        float_out <= {r_sign, {(W-1){1'b0}}};
`ifdef FLOAT_MUL_FLAGS_EN
                        flags     <= 4'b0011;
`endif
                    end else begin
                        float_out <= {r_sign, w_exp_rnd[EXP_W-1:0], w_frac};
`ifdef FLOAT_MUL_FLAGS_EN
                        flags     <= {3'b000, r_guard | r_sticky};
`endif
                    end
                    ready   <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    ready <= 1'b1;
                    if (!start) begin
                        ready   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_mul_param.sv
// Self-checking bench for float_mul_param (FP32 configuration).
// Latency is counted in rising edges after the edge that samples start.
module tb_float_mul_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] float_in_1;
    logic [31:0] float_in_2;
    logic [31:0] float_out;
    logic        ready;
`ifdef FLOAT_MUL_FLAGS_EN
    logic [3:0]  flags;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    float_mul_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .float_in_1 (float_in_1),
        .float_in_2 (float_in_2),
        .float_out  (float_out),
`ifdef FLOAT_MUL_FLAGS_EN
        .flags      (flags),
`endif
        .ready      (ready)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer product, rounded RNE to 24 significant bits
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic [3:0] flg,
                                    output int lat);
        int ea, eb, e, t, s;
        logic [63:0] p, q, rem, half;
        logic sr;
        bit na, nb, ia, ib, za, zb, inexact;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        za = (ea == 0);
        zb = (eb == 0);
        sr = a[31] ^ b[31];
        lat = 1;
        flg = 4'b0000;
        res = 32'h0;
        if (na || nb || (ia && zb) || (ib && za)) begin
            res = 32'h7FC00000;
            flg = 4'b1000;
        end else if (ia || ib) begin
            res = {sr, 8'hFF, 23'd0};
        end else if (za || zb) begin
            res = {sr, 31'd0};
        end else begin
            lat = 27;
            p = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
            t = 63;
            while (t > 0 && !p[t]) t = t - 1;
            e = ea + eb - 127 + (t - 46);
            s = t - 23;
            q = p >> s;
            rem = p - (q << s);
            half = 64'd1 << (s - 1);
            inexact = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q[24]) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                res = {sr, 8'hFF, 23'd0};
                flg = 4'b0101;
            end else if (e <= 0) begin
                res = {sr, 31'd0};
                flg = 4'b0011;
            end else begin
                res = {sr, e[7:0], q[22:0]};
                flg = {3'b000, inexact};
            end
        end
    endfunction

    // Double -> single conversion (RNE), normal range only
    function automatic logic [31:0] f32_of_real(input real r);
        logic [63:0] d, m, q, rem;
        int e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        m = {11'd0, 1'b1, d[51:0]};
        q = m >> 29;
        rem = m & 64'h1FFF_FFFF;
        if (rem > 64'h1000_0000 || (rem == 64'h1000_0000 && q[0])) q = q + 1;
        if (q[24]) begin
            q = q >> 1;
            e = e + 1;
        end
        return {d[63], e[7:0], q[22:0]};
    endfunction

    function automatic real real_of_f32(input logic [31:0] f);
        logic [10:0] de;
        de = 11'(int'(f[30:23]) + 896);
        return $bitstoreal({f[31], de, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] rand_op();
        int sel;
        logic [7:0] e;
        logic [22:0] fr;
        sel = $urandom_range(0, 19);
        fr = 23'($urandom);
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2: begin e = 8'hFF; fr = 23'd0; end
            3:       e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(90, 165));
        endcase
        return {1'($urandom_range(0, 1)), e, fr};
    endfunction

    // One full transaction: request, wait for ready, release, confirm ready drop
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                          output logic [31:0] res, output logic [3:0] flg, output int lat);
        bit ok;
        @(negedge clk);
        float_in_1 = a;
        float_in_2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        float_in_1 = $urandom;
        float_in_2 = $urandom;
        lat = 0;
        while (!ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = float_out;
`ifdef FLOAT_MUL_FLAGS_EN
        flg = flags;
`else
        flg = 4'b0000;
`endif
        if (hold) begin
            ok = 1'b1;
            repeat (5) begin
                @(posedge clk);
                #1;
                if (!ready || float_out !== res) ok = 1'b0;
            end
            check("hold_stable", 64'(ok), 64'd1);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("ready_drop", 64'(ready), 64'd0);
        check("out_retained", 64'(float_out), 64'(res));
    endtask

    task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic [3:0] ef, input int el,
                            input bit hold);
        logic [31:0] r;
        logic [3:0]  f;
        int          l;
        run_op(a, b, hold, r, f, l);
        check({tag, "_res"}, 64'(r), 64'(er));
        check({tag, "_lat"}, 64'(l), 64'(el));
`ifdef FLOAT_MUL_FLAGS_EN
        check({tag, "_flags"}, 64'(f), 64'(ef));
`else
        if (f != ef && ef == 4'hF) $display("unexpected flags");
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[14];
        logic [31:0] a, b, er, r;
        logic [3:0]  ef, f;
        int          el, l;
        bit          quiet;

        rst = 1'b1;
        start = 1'b0;
        float_in_1 = '0;
        float_in_2 = '0;
        #12;
        check("reset_out", 64'(float_out), 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27};
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 27};
        vecs[2]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 27};
        vecs[3]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 27};
        vecs[4]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 27};
        vecs[5]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1};
        vecs[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1};
        vecs[7]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 1};
        vecs[8]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, 1};
        vecs[9]  = '{32'hFF800000, 32'hFF800000, 32'h7F800000, 4'b0000, 1};
        vecs[10] = '{32'hBF800000, 32'h7F800001, 32'h7FC00000, 4'b1000, 1};
        vecs[11] = '{32'h00400000, 32'h40000000, 32'h00000000, 4'b0000, 1};
        vecs[12] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 27};
        vecs[13] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 27};

        for (int i = 0; i < 14; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                     vecs[i].res, vecs[i].flg, vecs[i].lat, 1'b0);
        end

        // start held through DONE: result stays valid until start falls
        check_op("hold", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27, 1'b1);

        // reset during MULT aborts the operation and clears outputs at once
        @(negedge clk);
        float_in_1 = 32'h40490FDB;
        float_in_2 = 32'h3FC00000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", 64'(ready), 64'd0);
        check("rst_mid_out", 64'(float_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (ready || float_out != 32'h0) quiet = 1'b0;
        end
        check("no_result_after_abort", 64'(quiet), 64'd1);
        ref_mul(32'h40490FDB, 32'h3FC00000, er, ef, el);
        check_op("after_rst", 32'h40490FDB, 32'h3FC00000, er, ef, el, 1'b0);

        // decimal operands converted to single precision, compared with double product rounded
        a = f32_of_real(10231.9382123417);
        b = f32_of_real(1334.921243746);
        er = f32_of_real(real_of_f32(a) * real_of_f32(b));
        run_op(a, b, 1'b0, r, f, l);
        check("big_product", 64'(r), 64'(er));
        check("big_product_lat", 64'(l), 64'd27);

        // randomised operands against the reference model
        for (int i = 0; i < 150; i++) begin
            a = rand_op();
            b = rand_op();
            ref_mul(a, b, er, ef, el);
            run_op(a, b, 1'b0, r, f, l);
            check($sformatf("rnd%0d_res a=%h b=%h", i, a, b), 64'(r), 64'(er));
            check($sformatf("rnd%0d_lat", i), 64'(l), 64'(el));
`ifdef FLOAT_MUL_FLAGS_EN
            check($sformatf("rnd%0d_flags", i), 64'(f), 64'(ef));
`endif
            if (el == 27 && ef[2:1] == 2'b00) begin
                check($sformatf("rnd%0d_real", i), 64'(r),
                      64'(f32_of_real(real_of_f32(a) * real_of_f32(b))));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
